// File: rtl/count_seq_pkg.sv
// Shared command, state and START-flag definitions for the count sequencer.
package count_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_PRESC = 2'b01,
    OP_START = 2'b10,
    OP_STOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int FLAG_ONESHOT = 0;
  localparam int FLAG_DOWN    = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a tick every prescale+1 cycles while run is high; clr restarts the period.
// Combinational tick from the registered pre_cnt; no backpressure.
module tick_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  // A clear on the same cycle swallows the tick, so commands take priority.
  assign tick = run && !clr && (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (rst || clr || !run || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven up/down counter with prescaler, terminal-count strobe and registered output enable.
// Commands take effect one cycle after acceptance; cmd_ready drops for that cycle (1 accept per 2 cycles).
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8   // must not exceed WIDTH; prescale comes from cmd_data
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             oe_req,
  output logic [WIDTH-1:0] count_q,
  output logic             count_oe,
  output logic             tc_pulse,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             pend_vld;
  cmd_op_e          pend_op;
  logic [WIDTH-1:0] pend_data;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] count_d;
  logic             oneshot_q, oneshot_d;
  logic             down_q, down_d;
  logic             tc_d;
  logic             terminal;
  logic             tick;

  assign cmd_ready = !rst && !pend_vld;
  assign busy      = (state_q == ST_RUN);

  tick_prescaler #(.PRE_W(PRE_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .run      (busy),
    .clr      (pend_vld),
    .prescale (presc_q),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_vld  <= 1'b0;
      pend_op   <= OP_LOAD;
      pend_data <= '0;
      presc_q   <= '0;
      count_q   <= '0;
      oneshot_q <= 1'b0;
      down_q    <= 1'b0;
      tc_pulse  <= 1'b0;
      count_oe  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      oneshot_q <= oneshot_d;
      down_q    <= down_d;
      tc_pulse  <= tc_d;
      count_oe  <= oe_req;
      if (cmd_valid && cmd_ready) begin
        pend_vld  <= 1'b1;
        pend_op   <= cmd_op_e'(cmd_op);
        pend_data <= cmd_data;
      end else begin
        pend_vld  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    count_d   = count_q;
    oneshot_d = oneshot_q;
    down_d    = down_q;
    tc_d      = 1'b0;
    terminal  = down_q ? (count_q == '0) : (count_q == '1);

    // A pending command always beats a coincident tick.
    if (pend_vld) begin
      case (pend_op)
        OP_LOAD:  count_d = pend_data;
        OP_PRESC: presc_d = pend_data[PRE_W-1:0];
        OP_START: begin
          oneshot_d = pend_data[FLAG_ONESHOT];
          down_d    = pend_data[FLAG_DOWN];
          state_d   = ST_RUN;
        end
        OP_STOP:  state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end else if (tick) begin
      tc_d = terminal;
      if (terminal && oneshot_q) begin
        state_d = ST_DONE;
      end else if (down_q) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

endmodule
